// File: rtl/datapath_controller.sv
// Multi-cycle control unit for the 64-bit LEGv8-subset datapath.
// Fetches into an internal IR, decodes it and sequences the control word across 1-3 cycles.
module datapath_controller #(
    parameter int          PC_STEP  = 4,
    parameter logic [4:0]  FS_AND   = 5'b00000,
    parameter logic [4:0]  FS_ORR   = 5'b00100,
    parameter logic [4:0]  FS_ADD   = 5'b01000,
    parameter logic [4:0]  FS_SUB   = 5'b01001,
    parameter logic [4:0]  FS_EOR   = 5'b01100,
    parameter logic [4:0]  LINK_REG = 5'd30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] instr,
    input  logic [4:0]  status,
    output logic [63:0] k,
    output logic [4:0]  reg_addr,
    output logic [4:0]  a_addr,
    output logic [4:0]  b_addr,
    output logic [4:0]  fs,
    output logic [1:0]  ps,
    output logic        reg_w,
    output logic        b_sel,
    output logic        b_en,
    output logic        alu_en,
    output logic        mem_en,
    output logic        chip_sel,
    output logic        mem_w,
    output logic        mem_r,
    output logic        stat_en,
    output logic        pc_reg_en,
    output logic        pc_rom_en,
    output logic        pc_sel,
    output logic        c0,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEM2,
        BRANCH,
        HALT
    } state_t;

    localparam logic [63:0] STEP64 = 64'(PC_STEP);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        taken_q, taken_d;
    logic        illegal_q, illegal_d;

    logic isAdd, isSub, isSubs, isAnd, isOrr, isEor;
    logic isAddi, isSubi, isLdur, isStur, isB, isBl, isCbz, isCbnz, isBr, isHlt;
    logic isRtype, isImm;
    logic [4:0]  aluFs;
    logic [63:0] imm9Ext, imm19Ext, imm26Ext, brImm, brOffset;
    logic        status_unused;

    // Only the combinational zero flag steers control; the rest of status belongs to the datapath.
    assign status_unused = ^status[4:1];

    assign isAdd   = (ir_q[31:21] == 11'b10001011000);
    assign isSub   = (ir_q[31:21] == 11'b11001011000);
    assign isSubs  = (ir_q[31:21] == 11'b11101011000);
    assign isAnd   = (ir_q[31:21] == 11'b10001010000);
    assign isOrr   = (ir_q[31:21] == 11'b10101010000);
    assign isEor   = (ir_q[31:21] == 11'b11001010000);
    assign isAddi  = (ir_q[31:22] == 10'b1001000100);
    assign isSubi  = (ir_q[31:22] == 10'b1101000100);
    assign isLdur  = (ir_q[31:21] == 11'b11111000010);
    assign isStur  = (ir_q[31:21] == 11'b11111000000);
    assign isB     = (ir_q[31:26] == 6'b000101);
    assign isBl    = (ir_q[31:26] == 6'b100101);
    assign isCbz   = (ir_q[31:24] == 8'b10110100);
    assign isCbnz  = (ir_q[31:24] == 8'b10110101);
    assign isBr    = (ir_q[31:21] == 11'b11010110000);
    assign isHlt   = (ir_q == 32'hFFFF_FFFF);
    assign isRtype = isAdd | isSub | isSubs | isAnd | isOrr | isEor;
    assign isImm   = isAddi | isSubi;

    // Branch offset backs out the FETCH increment so the target is relative to the branch itself.
    assign imm9Ext  = {{55{ir_q[20]}}, ir_q[20:12]};
    assign imm19Ext = {{45{ir_q[23]}}, ir_q[23:5]};
    assign imm26Ext = {{38{ir_q[25]}}, ir_q[25:0]};
    assign brImm    = (isB | isBl) ? imm26Ext : imm19Ext;
    assign brOffset = (brImm * STEP64) - STEP64;

    always_comb begin
        aluFs = FS_ADD;
        if (isSub | isSubs | isSubi) begin
            aluFs = FS_SUB;
        end else if (isAnd) begin
            aluFs = FS_AND;
        end else if (isOrr) begin
            aluFs = FS_ORR;
        end else if (isEor) begin
            aluFs = FS_EOR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        k         = '0;
        reg_addr  = '0;
        a_addr    = '0;
        b_addr    = '0;
        fs        = FS_ADD;
        ps        = 2'b00;
        reg_w     = 1'b0;
        b_sel     = 1'b0;
        b_en      = 1'b0;
        alu_en    = 1'b0;
        mem_en    = 1'b0;
        chip_sel  = 1'b0;
        mem_w     = 1'b0;
        mem_r     = 1'b0;
        stat_en   = 1'b0;
        pc_reg_en = 1'b0;
        pc_rom_en = 1'b0;
        pc_sel    = 1'b0;
        c0        = 1'b0;
        halted    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                pc_rom_en = 1'b1;
                ps        = 2'b01;
                ir_d      = instr;
                state_d   = EXEC;
            end
            EXEC: begin
                if (isRtype | isImm) begin
                    a_addr   = ir_q[9:5];
                    b_addr   = ir_q[20:16];
                    reg_addr = ir_q[4:0];
                    b_sel    = isImm;
                    k        = isImm ? {52'b0, ir_q[21:10]} : '0;
                    fs       = aluFs;
                    c0       = isSub | isSubs | isSubi;
                    alu_en   = 1'b1;
                    reg_w    = 1'b1;
                    stat_en  = isSubs;
                    state_d  = run ? FETCH : IDLE;
                end else if (isLdur | isStur) begin
                    a_addr  = ir_q[9:5];
                    b_sel   = 1'b1;
                    k       = imm9Ext;
                    fs      = FS_ADD;
                    alu_en  = 1'b1;
                    mem_en  = 1'b1;
                    mem_r   = isLdur;
                    state_d = MEM2;
                end else if (isB | isBl) begin
                    taken_d = 1'b1;
                    if (isBl) begin
                        pc_reg_en = 1'b1;
                        reg_addr  = LINK_REG;
                        reg_w     = 1'b1;
                    end
                    state_d = BRANCH;
                end else if (isCbz | isCbnz) begin
                    a_addr  = ir_q[4:0];
                    b_sel   = 1'b1;
                    fs      = FS_ORR;
                    taken_d = isCbz ? status[0] : ~status[0];
                    state_d = BRANCH;
                end else if (isBr) begin
                    a_addr  = ir_q[9:5];
                    pc_sel  = 1'b0;
                    ps      = 2'b10;
                    state_d = run ? FETCH : IDLE;
                end else if (isHlt) begin
                    state_d = HALT;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = HALT;
                end
            end
            MEM2: begin
                if (isLdur) begin
                    chip_sel = 1'b1;
                    reg_addr = ir_q[4:0];
                    reg_w    = 1'b1;
                end else begin
                    b_addr = ir_q[4:0];
                    b_en   = 1'b1;
                    mem_w  = 1'b1;
                end
                state_d = run ? FETCH : IDLE;
            end
            BRANCH: begin
                if (taken_q) begin
                    pc_sel = 1'b1;
                    ps     = 2'b11;
                    k      = brOffset;
                end
                taken_d = 1'b0;
                state_d = run ? FETCH : IDLE;
            end
            HALT: begin
                halted = 1'b1;
                if (!run) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
